// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared definitions for the EX-stage forwarding / hazard scoreboard.
// Select encodings used on fwd_sel_o:
//   SEL_REGFILE (0)    operand comes from the register file
//   sel_stage(k)       operand comes from pipeline stage k (k+1)
//   sel_mc(NUM_STAGES) operand comes from the multi-cycle result bus
// sb_entry_t is a debug view of one scoreboard slot in the default configuration.
package fwd_pkg;

  localparam int SEL_REGFILE = 0;

  localparam int DEF_REG_AW  = 5;
  localparam int DEF_MAX_LAT = 8;
  localparam int DEF_CNT_W   = $clog2(DEF_MAX_LAT + 1);

  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_CNT_W-1:0]  cnt;
  } sb_entry_t;

  function automatic int sel_stage(input int k);
    return k + 1;
  endfunction

  function automatic int sel_mc(input int num_stages);
    return num_stages + 1;
  endfunction

  // A latency of 0 still needs one cycle; anything beyond the table's
  // counter range is treated as the maximum.
  function automatic int clamp_lat(input int lat, input int max_lat);
    if (lat < 1) return 1;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_sb_entry.sv
// One scoreboard slot for an outstanding multi-cycle write.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   alloc, alloc_rd,    load the slot with a new op (wins over everything)
//   alloc_cnt
//   grant               this slot's completion is accepted this cycle
//   chk_rs, chk_rd      ID source / destination addresses to compare against
//   valid, rd           slot contents
//   ready               slot has reached its last cycle (cnt==1)
//   rs_hit, rd_hit      slot is pending (valid, not completing now, rd!=0) and
//                       its rd equals the corresponding ID address
module sb_entry #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc,
  input  logic [REG_AW-1:0]         alloc_rd,
  input  logic [CNT_W-1:0]          alloc_cnt,
  input  logic                      grant,
  input  logic [NUM_SRC*REG_AW-1:0] chk_rs,
  input  logic [REG_AW-1:0]         chk_rd,
  output logic                      valid,
  output logic [REG_AW-1:0]         rd,
  output logic                      ready,
  output logic [NUM_SRC-1:0]        rs_hit,
  output logic                      rd_hit
);

  logic [CNT_W-1:0] cnt;
  logic             pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      rd    <= '0;
      cnt   <= '0;
    end else if (alloc) begin
      valid <= 1'b1;
      rd    <= alloc_rd;
      cnt   <= alloc_cnt;
    end else if (grant) begin
      valid <= 1'b0;
    end else if (valid && cnt > CNT_W'(1)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // A ready slot that lost arbitration simply sits at cnt==1 until granted.
  assign ready   = valid && (cnt == CNT_W'(1));
  // Register 0 is never a real dependency, and a completing slot's value is
  // already on the MC bus, so neither counts as pending.
  assign pending = valid && !grant && (rd != '0);
  assign rd_hit  = pending && (rd == chk_rd);

  always_comb begin
    rs_hit = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      rs_hit[n] = pending && (rd == chk_rs[n*REG_AW +: REG_AW]);
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// EX-stage forwarding unit with hazard detection and a scoreboard of
// outstanding multi-cycle (MUL/DIV) writes.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   ex_rs_i            EX source addresses (operand n at [n*REG_AW +: REG_AW])
//   stg_wen_i/rd_i/rdy_i  per forwarding stage: writes, destination, result ready
//   id_rs_i, id_wen_i, id_rd_i  ID sources and destination
//   mc_issue_i, mc_rd_i, mc_lat_i  multi-cycle issue from ID
//   fwd_sel_o          per-operand select (0 regfile, k+1 stage k, NUM_STAGES+1 MC bus)
//   stall_o            hold IF/ID, bubble into EX
//   mc_done_o, mc_done_rd_o  one entry completes this cycle, and its rd
//   mc_full_o          no entry free once this cycle's completion is counted
//   mc_ovf_o           sticky: an issue was attempted while full
// Issue contract: mc_issue_i is a one-cycle request; it is accepted exactly
// when mc_full_o is low in the same cycle, otherwise dropped and recorded in
// mc_ovf_o. stall_o is advisory to ID and does not gate acceptance.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int  NUM_SRC    = 2,
  parameter int  NUM_STAGES = 2,
  parameter int  REG_AW     = 5,
  parameter int  NUM_MC     = 4,
  parameter int  MAX_LAT    = 8,
  localparam int SEL_W      = $clog2(NUM_STAGES + 2),
  localparam int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_SRC*REG_AW-1:0]     ex_rs_i,
  input  logic [NUM_STAGES-1:0]         stg_wen_i,
  input  logic [NUM_STAGES*REG_AW-1:0]  stg_rd_i,
  input  logic [NUM_STAGES-1:0]         stg_rdy_i,
  input  logic [NUM_SRC*REG_AW-1:0]     id_rs_i,
  input  logic                          id_wen_i,
  input  logic [REG_AW-1:0]             id_rd_i,
  input  logic                          mc_issue_i,
  input  logic [REG_AW-1:0]             mc_rd_i,
  input  logic [LAT_W-1:0]              mc_lat_i,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
  output logic                          stall_o,
  output logic                          mc_done_o,
  output logic [REG_AW-1:0]             mc_done_rd_o,
  output logic                          mc_full_o,
  output logic                          mc_ovf_o
);

  logic [NUM_MC-1:0]  valid, ready, grant, free, alloc, rd_hit;
  logic [REG_AW-1:0]  ent_rd [NUM_MC];
  logic [NUM_SRC-1:0] rs_hit [NUM_MC];
  logic [LAT_W-1:0]   alloc_cnt;
  logic               done, full, accept, taken;
  logic [REG_AW-1:0]  done_rd;

  for (genvar i = 0; i < NUM_MC; i++) begin : g_entry
    sb_entry #(
      .NUM_SRC (NUM_SRC),
      .REG_AW  (REG_AW),
      .CNT_W   (LAT_W)
    ) u_entry (
      .clk       (clk_i),
      .rst       (rst_i),
      .alloc     (alloc[i]),
      .alloc_rd  (mc_rd_i),
      .alloc_cnt (alloc_cnt),
      .grant     (grant[i]),
      .chk_rs    (id_rs_i),
      .chk_rd    (id_rd_i),
      .valid     (valid[i]),
      .rd        (ent_rd[i]),
      .ready     (ready[i]),
      .rs_hit    (rs_hit[i]),
      .rd_hit    (rd_hit[i])
    );
  end

  // Completion arbitration: only one result bus, lowest ready slot wins.
  always_comb begin
    grant   = '0;
    done    = 1'b0;
    done_rd = '0;
    for (int i = 0; i < NUM_MC; i++) begin
      if (ready[i] && !done) begin
        grant[i] = 1'b1;
        done     = 1'b1;
        done_rd  = ent_rd[i];
      end
    end
  end

  // The slot completing this cycle can be refilled in the same cycle.
  assign free      = ~valid | grant;
  assign full      = ~|free;
  assign accept    = mc_issue_i && !full;
  assign alloc_cnt = LAT_W'(clamp_lat(int'(mc_lat_i), MAX_LAT));

  always_comb begin
    alloc = '0;
    taken = 1'b0;
    for (int i = 0; i < NUM_MC; i++) begin
      if (free[i] && !taken) begin
        alloc[i] = accept;
        taken    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mc_ovf_o <= 1'b0;
    end else if (mc_issue_i && full) begin
      mc_ovf_o <= 1'b1;
    end
  end

  assign mc_done_o    = done;
  assign mc_done_rd_o = done_rd;
  assign mc_full_o    = full;

  // Forwarding mux select. The MC bus beats every stage: a later same-rd
  // producer cannot exist because ID stalls on WAW against pending entries.
  logic [REG_AW-1:0] ex_src;
  logic              sel_busy;
  logic              proto_err;

  always_comb begin
    fwd_sel_o = {NUM_SRC{SEL_W'(SEL_REGFILE)}};
    ex_src    = '0;
    sel_busy  = 1'b0;
    proto_err = 1'b0;
    for (int n = 0; n < NUM_SRC; n++) begin
      ex_src   = ex_rs_i[n*REG_AW +: REG_AW];
      sel_busy = 1'b0;
      if (ex_src != '0) begin
        // Walk oldest to youngest so the youngest matching stage is left.
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
          if (stg_wen_i[k] && (stg_rd_i[k*REG_AW +: REG_AW] == ex_src)) begin
            fwd_sel_o[n*SEL_W +: SEL_W] = SEL_W'(sel_stage(k));
            sel_busy = !stg_rdy_i[k];
          end
        end
        if (done && (done_rd == ex_src)) begin
          fwd_sel_o[n*SEL_W +: SEL_W] = SEL_W'(sel_mc(NUM_STAGES));
          sel_busy = 1'b0;
        end
      end
      proto_err = proto_err | sel_busy;
    end
  end

  // Hazard detection for the instruction sitting in ID.
  logic [REG_AW-1:0] id_src;

  always_comb begin
    stall_o = full && mc_issue_i;
    id_src  = '0;
    if (id_wen_i && (id_rd_i != '0) && (|rd_hit)) begin
      stall_o = 1'b1;
    end
    for (int n = 0; n < NUM_SRC; n++) begin
      id_src = id_rs_i[n*REG_AW +: REG_AW];
      if ((id_src != '0) && stg_wen_i[0] && !stg_rdy_i[0] &&
          (stg_rd_i[0 +: REG_AW] == id_src)) begin
        stall_o = 1'b1;
      end
      for (int i = 0; i < NUM_MC; i++) begin
        if (rs_hit[i][n]) stall_o = 1'b1;
      end
    end
  end

  // An EX operand must never take its value from a stage whose result has
  // not arrived yet; ID should have stalled it.
  a_no_busy_fwd: assert property (@(posedge clk_i) disable iff (rst_i) !proto_err);

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: directed scenarios followed by random
// traffic, all compared against a slot-level reference model.
module tb_fwd_hazard_scoreboard;

  localparam int NUM_SRC    = 2;
  localparam int NUM_STAGES = 2;
  localparam int REG_AW     = 5;
  localparam int NUM_MC     = 4;
  localparam int MAX_LAT    = 8;
  localparam int SEL_W      = 2;
  localparam int LAT_W      = 4;
  // expected vector: {sel[3:0], stall, done, done_rd[4:0], full, ovf}
  localparam int W          = 13;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_SRC*REG_AW-1:0]    ex_rs, id_rs;
  logic [NUM_STAGES-1:0]        stg_wen, stg_rdy;
  logic [NUM_STAGES*REG_AW-1:0] stg_rd;
  logic                         id_wen, mc_issue;
  logic [REG_AW-1:0]            id_rd, mc_rd;
  logic [LAT_W-1:0]             mc_lat;
  logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
  logic                         stall, mc_done, mc_full, mc_ovf;
  logic [REG_AW-1:0]            mc_done_rd;

  fwd_hazard_scoreboard #(
    .NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES), .REG_AW(REG_AW),
    .NUM_MC(NUM_MC), .MAX_LAT(MAX_LAT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ex_rs_i      (ex_rs),
    .stg_wen_i    (stg_wen),
    .stg_rd_i     (stg_rd),
    .stg_rdy_i    (stg_rdy),
    .id_rs_i      (id_rs),
    .id_wen_i     (id_wen),
    .id_rd_i      (id_rd),
    .mc_issue_i   (mc_issue),
    .mc_rd_i      (mc_rd),
    .mc_lat_i     (mc_lat),
    .fwd_sel_o    (fwd_sel),
    .stall_o      (stall),
    .mc_done_o    (mc_done),
    .mc_done_rd_o (mc_done_rd),
    .mc_full_o    (mc_full),
    .mc_ovf_o     (mc_ovf)
  );

  // ---------------- counters / compare ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each slot: an outstanding write to rd with rem cycles left to completion.
  int m_valid [NUM_MC];
  int m_rd    [NUM_MC];
  int m_rem   [NUM_MC];
  int m_ovf;

  function automatic int m_winner();
    for (int i = 0; i < NUM_MC; i++)
      if (m_valid[i] != 0 && m_rem[i] == 1) return i;
    return -1;
  endfunction

  function automatic bit m_full();
    int c = m_winner();
    for (int i = 0; i < NUM_MC; i++)
      if (m_valid[i] == 0 || i == c) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_pending(input int r);
    int c = m_winner();
    for (int i = 0; i < NUM_MC; i++)
      if (m_valid[i] != 0 && i != c && m_rd[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] e = '0;
    int c = m_winner();
    int rs, s;
    bit found, st;
    for (int n = 0; n < NUM_SRC; n++) begin
      rs = int'(ex_rs[n*REG_AW +: REG_AW]);
      s = 0;
      if (rs != 0) begin
        if (c >= 0 && m_rd[c] == rs) s = NUM_STAGES + 1;
        else begin
          found = 1'b0;
          for (int k = 0; k < NUM_STAGES; k++)
            if (!found && stg_wen[k] && int'(stg_rd[k*REG_AW +: REG_AW]) == rs) begin
              s = k + 1;
              found = 1'b1;
            end
        end
      end
      e[9 + n*SEL_W +: SEL_W] = SEL_W'(s);
    end
    st = m_full() && mc_issue;
    if (id_wen && id_rd != 0 && m_pending(int'(id_rd))) st = 1'b1;
    for (int n = 0; n < NUM_SRC; n++) begin
      rs = int'(id_rs[n*REG_AW +: REG_AW]);
      if (rs != 0) begin
        if (stg_wen[0] && !stg_rdy[0] && int'(stg_rd[REG_AW-1:0]) == rs) st = 1'b1;
        if (m_pending(rs)) st = 1'b1;
      end
    end
    e[8]   = st;
    e[7]   = (c >= 0);
    e[6:2] = (c >= 0) ? REG_AW'(m_rd[c]) : '0;
    e[1]   = m_full();
    e[0]   = (m_ovf != 0);
    return e;
  endfunction

  task automatic model_step();
    int c = m_winner();
    bit full = m_full();
    int slot = -1;
    int lat;
    for (int i = 0; i < NUM_MC; i++)
      if (slot < 0 && (m_valid[i] == 0 || i == c)) slot = i;
    for (int i = 0; i < NUM_MC; i++) begin
      if (i == c) m_valid[i] = 0;
      else if (m_valid[i] != 0 && m_rem[i] > 1) m_rem[i]--;
    end
    if (mc_issue) begin
      if (full) m_ovf = 1;
      else begin
        lat = int'(mc_lat);
        if (lat < 1) lat = 1;
        if (lat > MAX_LAT) lat = MAX_LAT;
        m_valid[slot] = 1;
        m_rd[slot]    = int'(mc_rd);
        m_rem[slot]   = lat;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_MC; i++) begin
      m_valid[i] = 0;
      m_rd[i]    = 0;
      m_rem[i]   = 0;
    end
    m_ovf = 0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int n = 0; n < NUM_SRC; n++)
        chk("fwd_sel", int'(fwd_sel[n*SEL_W +: SEL_W]), int'(mon_e[9 + n*SEL_W +: SEL_W]));
      chk("stall", int'(stall), int'(mon_e[8]));
      chk("mc_done", int'(mc_done), int'(mon_e[7]));
      chk("mc_done_rd", int'(mc_done_rd), int'(mon_e[6:2]));
      chk("mc_full", int'(mc_full), int'(mon_e[1]));
      chk("mc_ovf", int'(mc_ovf), int'(mon_e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    ex_rs = '0; id_rs = '0; stg_wen = '0; stg_rd = '0; stg_rdy = '1;
    id_wen = 1'b0; id_rd = '0; mc_issue = 1'b0; mc_rd = '0; mc_lat = '0;
  endtask

  // Called shortly after a rising edge with inputs already applied.
  task automatic step();
    exp_q.push_back(model_out());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic issue(input int rd, input int lat);
    idle();
    mc_issue = 1'b1;
    mc_rd    = REG_AW'(rd);
    mc_lat   = LAT_W'(lat);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_fwd_sel"}, int'(fwd_sel), 0);
    chk({tag, "_stall"}, int'(stall), 0);
    chk({tag, "_done"}, int'(mc_done), 0);
    chk({tag, "_done_rd"}, int'(mc_done_rd), 0);
    chk({tag, "_full"}, int'(mc_full), 0);
    chk({tag, "_ovf"}, int'(mc_ovf), 0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle();
    #3;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // forwarding priority among stages
    stg_wen = 2'b11; stg_rd = {5'd5, 5'd5}; ex_rs = {5'd0, 5'd5};
    #1 chk("fwd_stage0", int'(fwd_sel[1:0]), 1);
    step();
    stg_wen = 2'b10;
    #1 chk("fwd_stage1", int'(fwd_sel[1:0]), 2);
    step();
    ex_rs = '0;
    #1 chk("fwd_rs0", int'(fwd_sel[1:0]), 0);
    step();

    // load-use
    idle(); stg_wen = 2'b01; stg_rd = {5'd0, 5'd7}; stg_rdy = 2'b10; id_rs = {5'd7, 5'd0};
    #1 chk("load_use_stall", int'(stall), 1);
    step();
    stg_rdy = 2'b11;
    #1 chk("load_use_clear", int'(stall), 0);
    step();

    // multi-cycle latency 3, RAW pending, MC bus priority
    issue(9, 3);
    idle(); id_rs = {5'd0, 5'd9};
    #1 chk("raw_stall_t1", int'(stall), 1);
    chk("no_done_t1", int'(mc_done), 0);
    step();
    #1 chk("raw_stall_t2", int'(stall), 1);
    step();
    ex_rs = {5'd0, 5'd9}; stg_wen = 2'b01; stg_rd = {5'd0, 5'd9};
    #1 chk("done_t3", int'(mc_done), 1);
    chk("done_rd_t3", int'(mc_done_rd), 9);
    chk("fwd_mc", int'(fwd_sel[1:0]), NUM_STAGES + 1);
    chk("raw_clear_t3", int'(stall), 0);
    step();
    idle(); step();

    // fill, overflow, refill on completion
    for (int i = 0; i < NUM_MC; i++) issue(10 + i, 8);
    idle(); mc_issue = 1'b1; mc_rd = 5'd20; mc_lat = 4'd2;
    #1 chk("full", int'(mc_full), 1);
    chk("full_issue_stall", int'(stall), 1);
    step();
    idle();
    #1 chk("ovf_set", int'(mc_ovf), 1);
    step(); step(); step();
    mc_issue = 1'b1; mc_rd = 5'd21; mc_lat = 4'd1;
    #1 chk("full_freed_by_done", int'(mc_full), 0);
    chk("done_rd_slot0", int'(mc_done_rd), 10);
    step();
    idle();
    #1 chk("tie_lowest_wins", int'(mc_done_rd), 21);
    for (int i = 0; i < 5; i++) step();
    #1 chk("ovf_sticky", int'(mc_ovf), 1);

    // WAW and latency clamping
    issue(3, 4);
    idle(); id_wen = 1'b1; id_rd = 5'd3;
    #1 chk("waw_stall", int'(stall), 1);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    issue(4, 0);
    #1 chk("lat0_done", int'(mc_done), 1);
    chk("lat0_rd", int'(mc_done_rd), 4);
    step();
    issue(6, 15);
    for (int i = 1; i < 8; i++) begin
      #1 chk("lat15_wait", int'(mc_done), 0);
      step();
    end
    #1 chk("lat15_done", int'(mc_done), 1);
    chk("lat15_rd", int'(mc_done_rd), 6);
    step();

    // reset with pending entries
    issue(1, 8); issue(2, 8); issue(3, 8);
    idle(); step();
    #1 rst = 1'b1;
    #1 check_all_zero("async_reset");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 chk("no_done_after_reset", int'(mc_done), 0);
      step();
    end

    // random traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      stg_wen  = NUM_STAGES'($urandom_range(0, 3));
      stg_rd   = {REG_AW'($urandom_range(0, 12)), REG_AW'($urandom_range(0, 12))};
      stg_rdy  = {1'b1, ($urandom_range(0, 3) != 0)};
      ex_rs    = {REG_AW'($urandom_range(0, 12)), REG_AW'($urandom_range(0, 12))};
      id_rs    = {REG_AW'($urandom_range(0, 12)), REG_AW'($urandom_range(0, 12))};
      id_wen   = ($urandom_range(0, 1) != 0);
      id_rd    = REG_AW'($urandom_range(0, 12));
      mc_issue = ($urandom_range(0, 2) == 0);
      mc_rd    = REG_AW'($urandom_range(0, 12));
      mc_lat   = LAT_W'($urandom_range(0, 15));
      // EX never forwards from a load that has not returned
      for (int n = 0; n < NUM_SRC; n++)
        if (stg_wen[0] && ex_rs[n*REG_AW +: REG_AW] != '0 &&
            ex_rs[n*REG_AW +: REG_AW] == stg_rd[REG_AW-1:0])
          stg_rdy[0] = 1'b1;
      step();
    end

    idle();
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
